// File: rtl/dec2to4_seq.sv
// Sequenced 2-to-4 decoder: each accepted code drives a one-hot y for HOLD_CYC
// cycles, separated by GAP_CYC zero cycles, with a one-entry pending slot.
module dec2to4_seq #(
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       e_valid,
  input  logic [1:0] e_in,
  output logic       e_ready,
  output logic [3:0] y,
  output logic       y_valid,
  output logic       busy,
  output logic       drop,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_RLD = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GAP_RLD  = 8'(GAP_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] y_q, y_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       pend_full_q, pend_full_d;
  logic [1:0] pend_code_q, pend_code_d;
  logic       drop_q, drop_d;
  logic       accept;

  function automatic logic [3:0] onehot(input logic [1:0] code);
    logic [3:0] r;
    r = 4'b0001 << code;
    return r;
  endfunction

  // Handshake: a code is taken on a rising edge where e_valid && e_ready;
  // e_ready depends only on the pending slot, never on e_valid.
  assign e_ready     = ~pend_full_q;
  assign accept      = e_valid & e_ready;
  assign y           = y_q;
  assign y_valid     = |y_q;
  assign busy        = (state_q != ST_IDLE) | pend_full_q;
  assign drop        = drop_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pend_full_d = pend_full_q;
    pend_code_d = pend_code_q;
    drop_d      = e_valid & ~e_ready;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_HOLD;
          y_d        = onehot(e_in);
          hold_cnt_d = HOLD_RLD;
        end
      end

      ST_HOLD: begin
        if (accept) begin
          pend_full_d = 1'b1;
          pend_code_d = e_in;
        end
        if (hold_cnt_q == 8'd0) begin
          state_d   = ST_GAP;
          y_d       = 4'b0000;
          gap_cnt_d = GAP_RLD;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          // The pending slot is older than anything arriving now, so it wins;
          // an accept here is only possible when the slot is empty.
          if (pend_full_q) begin
            state_d     = ST_HOLD;
            y_d         = onehot(pend_code_q);
            hold_cnt_d  = HOLD_RLD;
            pend_full_d = 1'b0;
          end else if (accept) begin
            state_d    = ST_HOLD;
            y_d        = onehot(e_in);
            hold_cnt_d = HOLD_RLD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
          if (accept) begin
            pend_full_d = 1'b1;
            pend_code_d = e_in;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        y_d     = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      y_q         <= 4'b0000;
      hold_cnt_q  <= 8'd0;
      gap_cnt_q   <= 8'd0;
      pend_full_q <= 1'b0;
      pend_code_q <= 2'd0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pend_full_q <= pend_full_d;
      pend_code_q <= pend_code_d;
      drop_q      <= drop_d;
    end
  end

endmodule

// File: tb/tb_dec2to4_seq.sv
// Bench for dec2to4_seq: per-cycle vector table through an expected-value queue,
// plus a hand-written asynchronous reset sequence.
module tb_dec2to4_seq;

  logic       clk;
  logic       rst_n;
  logic       e_valid;
  logic [1:0] e_in;
  logic       e_ready;
  logic [3:0] y;
  logic       y_valid;
  logic       busy;
  logic       drop;
  logic [1:0] dbg_state;

  dec2to4_seq #(.HOLD_CYC(4), .GAP_CYC(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .e_valid     (e_valid),
    .e_in        (e_in),
    .e_ready     (e_ready),
    .y           (y),
    .y_valid     (y_valid),
    .busy        (busy),
    .drop        (drop),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] e;
    logic [3:0] y;
    logic       rdy;
    logic       drp;
    logic       bsy;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_main;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [1:0] e, input logic [3:0] ey,
                     input logic rdy, input logic drp, input logic bsy, input int n = 1);
    vec_t r;
    r.v = v; r.e = e; r.y = ey; r.rdy = rdy; r.drp = drp; r.bsy = bsy;
    for (int k = 0; k < n; k++) vecs.push_back(r);
  endtask

  // One cycle: drive inputs on the falling edge, check outputs 2ns later.
  // Packed layout is {y, y_valid, e_ready, drop, busy}.
  task automatic run_row(input int i, input bit release_rst);
    logic [7:0] act;
    logic [7:0] exp;
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    e_valid = vecs[i].v;
    e_in    = vecs[i].e;
    exp_q.push_back({vecs[i].y, |vecs[i].y, vecs[i].rdy, vecs[i].drp, vecs[i].bsy});
    #2;
    act = {y, y_valid, e_ready, drop, busy};
    exp = exp_q.pop_front();
    check($sformatf("row%0d", i), act, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_y"},       {4'b0, y},         8'h00);
    check({tag, "_y_valid"}, {7'b0, y_valid},   8'h00);
    check({tag, "_busy"},    {7'b0, busy},      8'h00);
    check({tag, "_drop"},    {7'b0, drop},      8'h00);
    check({tag, "_e_ready"}, {7'b0, e_ready},   8'h01);
    check({tag, "_state"},   {6'b0, dbg_state}, 8'h00);
  endtask

  initial begin
    // single code 2
    add(1, 2, 4'b0000, 1, 0, 0);
    add(0, 0, 4'b0100, 1, 0, 1, 4);
    add(0, 0, 4'b0000, 1, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 0);
    // back-to-back: 1 then 3 via pending slot
    add(1, 1, 4'b0000, 1, 0, 0);
    add(0, 0, 4'b0010, 1, 0, 1);
    add(1, 3, 4'b0010, 1, 0, 1);
    add(0, 0, 4'b0010, 0, 0, 1, 2);
    add(0, 0, 4'b0000, 0, 0, 1);
    add(0, 0, 4'b1000, 1, 0, 1, 4);
    add(0, 0, 4'b0000, 1, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 0);
    // overflow: code 0 offered while slot full is dropped
    add(1, 1, 4'b0000, 1, 0, 0);
    add(0, 0, 4'b0010, 1, 0, 1);
    add(1, 2, 4'b0010, 1, 0, 1);
    add(1, 0, 4'b0010, 0, 0, 1);
    add(0, 0, 4'b0010, 0, 1, 1);
    add(0, 0, 4'b0000, 0, 0, 1);
    add(0, 0, 4'b0100, 1, 0, 1, 4);
    add(0, 0, 4'b0000, 1, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 0);
    // bypass on the GAP terminal edge
    add(1, 0, 4'b0000, 1, 0, 0);
    add(0, 0, 4'b0001, 1, 0, 1, 4);
    add(1, 3, 4'b0000, 1, 0, 1);
    add(0, 0, 4'b1000, 1, 0, 1, 4);
    add(0, 0, 4'b0000, 1, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 0);
    // all codes in turn, each offered as soon as ready
    add(1, 0, 4'b0000, 1, 0, 0);
    add(1, 1, 4'b0001, 1, 0, 1);
    add(0, 0, 4'b0001, 0, 0, 1, 3);
    add(0, 0, 4'b0000, 0, 0, 1);
    add(1, 2, 4'b0010, 1, 0, 1);
    add(0, 0, 4'b0010, 0, 0, 1, 3);
    add(0, 0, 4'b0000, 0, 0, 1);
    add(1, 3, 4'b0100, 1, 0, 1);
    add(0, 0, 4'b0100, 0, 0, 1, 3);
    add(0, 0, 4'b0000, 0, 0, 1);
    add(0, 0, 4'b1000, 1, 0, 1, 4);
    add(0, 0, 4'b0000, 1, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 0);
    n_main = vecs.size();
    // after async reset: code 0 on the first edge; discarded pending must not appear
    add(1, 0, 4'b0000, 1, 0, 0);
    add(0, 0, 4'b0001, 1, 0, 1, 4);
    add(0, 0, 4'b0000, 1, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 0);

    rst_n   = 1'b0;
    e_valid = 1'b0;
    e_in    = 2'd0;
    #1;
    check_reset_state("por");
    repeat (2) @(posedge clk);

    for (int i = 0; i < n_main; i++) run_row(i, i == 0);

    // mid-HOLD reset with a full pending slot
    @(negedge clk);
    e_valid = 1'b1; e_in = 2'd2;
    #2;
    check("rst_seq_ready0", {7'b0, e_ready}, 8'h01);
    @(negedge clk);
    e_valid = 1'b1; e_in = 2'd3;
    #2;
    check("rst_seq_y", {4'b0, y}, 8'h04);
    @(negedge clk);
    e_valid = 1'b0; e_in = 2'd0;
    #2;
    check("rst_seq_slot_full", {6'b0, e_ready, busy}, 8'h01);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("async");
    @(posedge clk);
    #1;
    check("async_held_y", {4'b0, y}, 8'h00);

    for (int i = n_main; i < vecs.size(); i++) run_row(i, i == n_main);

    check("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
